vga_rect_plotter: RTL and testbench

//  Parametrised rectangle drawing engine that feeds the pixel-write port of vga_adapter.
//  It replaces the fixed single-pixel plot with a rectangle of programmable origin, size and colour.
//  The rectangle is drawn either filled or as a 1-pixel outline, one pixel per clock, in raster order.

---
 rtl/vga_rect_plotter_if.sv | 38 +++
 rtl/vga_rect_plotter.sv | 206 ++++++++++++++++++++
 tb/tb_vga_rect_plotter.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/vga_rect_plotter_if.sv
// vga_rect_plotter_if
//   Bundles the command handshake and the pixel-write bus of the rectangle
//   plotter into one connection.
//   Command side : start, x0, y0, w, h, color_in, outline  (master -> slave)
//                  busy, done                              (slave -> master)
//   Pixel side   : x, y, color, plot                       (slave -> master/adapter)
//   The master modport is the control FSM or testbench. The slave modport is
//   the plotter.
interface vga_rect_plotter_if #(
    parameter int X_W     = 8,
    parameter int Y_W     = 7,
    parameter int COLOR_W = 3
);
    logic               start;
    logic [X_W-1:0]     x0;
    logic [Y_W-1:0]     y0;
    logic [X_W-1:0]     w;
    logic [Y_W-1:0]     h;
    logic [COLOR_W-1:0] color_in;
    logic               outline;

    logic [X_W-1:0]     x;
    logic [Y_W-1:0]     y;
    logic [COLOR_W-1:0] color;
    logic               plot;
    logic               busy;
    logic               done;

    modport master (
        output start, x0, y0, w, h, color_in, outline,
        input  x, y, color, plot, busy, done
    );

    modport slave (
        input  start, x0, y0, w, h, color_in, outline,
        output x, y, color, plot, busy, done
    );
endinterface

// File: rtl/vga_rect_plotter.sv
// vga_rect_plotter
//   Draws a filled or outlined rectangle into the pixel-write port of
//   vga_adapter. It emits one pixel per clock in raster order (column
//   fastest). Pixels off the visible screen still take their cycle but are
//   not plotted.
//   Ports:
//     clk  - system clock
//     rst  - synchronous reset, active-high
//     bus  - vga_rect_plotter_if.slave. It carries the command operands,
//            start/busy/done, and the x/y/color/plot pixel outputs.
module vga_rect_plotter #(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COLOR_W  = 3,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic              clk,
    input  logic              rst,
    vga_rect_plotter_if.slave bus
);

    // Screen limits sized to match the widened coordinate sums.
    localparam logic [X_W:0] SCREEN_W_L = (X_W + 1)'(SCREEN_W);
    localparam logic [Y_W:0] SCREEN_H_L = (Y_W + 1)'(SCREEN_H);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [X_W-1:0]     x0_q, x0_d, w_q, w_d, col_q, col_d, x_q, x_d;
    logic [Y_W-1:0]     y0_q, y0_d, h_q, h_d, row_q, row_d, y_q, y_d;
    logic [COLOR_W-1:0] color_q, color_d;
    logic               outline_q, outline_d;
    logic               plot_q, plot_d;

    logic               accept;
    logic               zero_size;
    logic               last_pix;

    logic [X_W-1:0]     op_x0, op_w, nxt_col;
    logic [Y_W-1:0]     op_y0, op_h, nxt_row;
    logic               op_outline;
    logic [X_W:0]       sum_x;
    logic [Y_W:0]       sum_y;
    logic               visible;
    logic               on_border;

    // Command acceptance and end-of-rectangle detection.
    always_comb begin
        accept    = (state_q == IDLE) && bus.start;
        zero_size = (bus.w == '0) || (bus.h == '0);
        last_pix  = (col_q == w_q - X_W'(1)) && (row_q == h_q - Y_W'(1));
    end

    // Work out which pixel is presented next and whether it gets plotted.
    // On acceptance the operands come straight from the bus, because the
    // first pixel is registered in the same edge that latches them. The
    // sums are one bit wider so that a rectangle running off the right or
    // bottom edge clips instead of wrapping back onto the screen.
    always_comb begin
        if (accept) begin
            op_x0      = bus.x0;
            op_y0      = bus.y0;
            op_w       = bus.w;
            op_h       = bus.h;
            op_outline = bus.outline;
            nxt_col    = '0;
            nxt_row    = '0;
        end else begin
            op_x0      = x0_q;
            op_y0      = y0_q;
            op_w       = w_q;
            op_h       = h_q;
            op_outline = outline_q;
            if (col_q == w_q - X_W'(1)) begin
                nxt_col = '0;
                nxt_row = row_q + Y_W'(1);
            end else begin
                nxt_col = col_q + X_W'(1);
                nxt_row = row_q;
            end
        end
        sum_x     = {1'b0, op_x0} + {1'b0, nxt_col};
        sum_y     = {1'b0, op_y0} + {1'b0, nxt_row};
        visible   = (sum_x < SCREEN_W_L) && (sum_y < SCREEN_H_L);
        on_border = !op_outline
                 || (nxt_col == '0) || (nxt_col == op_w - X_W'(1))
                 || (nxt_row == '0) || (nxt_row == op_h - Y_W'(1));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. A zero-sized command goes straight to FIN so that
    // it still produces its done pulse.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = zero_size ? FIN : DRAW;
                end
            end
            DRAW: begin
                if (last_pix) begin
                    state_d = FIN;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output and datapath logic. x/y hold their value and plot drops
    // whenever no new pixel is being presented.
    always_comb begin
        x0_d      = x0_q;
        y0_d      = y0_q;
        w_d       = w_q;
        h_d       = h_q;
        color_d   = color_q;
        outline_d = outline_q;
        col_d     = col_q;
        row_d     = row_q;
        x_d       = x_q;
        y_d       = y_q;
        plot_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    x0_d      = bus.x0;
                    y0_d      = bus.y0;
                    w_d       = bus.w;
                    h_d       = bus.h;
                    color_d   = bus.color_in;
                    outline_d = bus.outline;
                    col_d     = '0;
                    row_d     = '0;
                    if (!zero_size) begin
                        x_d    = sum_x[X_W-1:0];
                        y_d    = sum_y[Y_W-1:0];
                        plot_d = visible && on_border;
                    end
                end
            end
            DRAW: begin
                if (!last_pix) begin
                    col_d  = nxt_col;
                    row_d  = nxt_row;
                    x_d    = sum_x[X_W-1:0];
                    y_d    = sum_y[Y_W-1:0];
                    plot_d = visible && on_border;
                end
            end
            default: ;
        endcase
    end

    // Operand, counter and pixel-output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            x0_q      <= '0;
            y0_q      <= '0;
            w_q       <= '0;
            h_q       <= '0;
            color_q   <= '0;
            outline_q <= 1'b0;
            col_q     <= '0;
            row_q     <= '0;
            x_q       <= '0;
            y_q       <= '0;
            plot_q    <= 1'b0;
        end else begin
            x0_q      <= x0_d;
            y0_q      <= y0_d;
            w_q       <= w_d;
            h_q       <= h_d;
            color_q   <= color_d;
            outline_q <= outline_d;
            col_q     <= col_d;
            row_q     <= row_d;
            x_q       <= x_d;
            y_q       <= y_d;
            plot_q    <= plot_d;
        end
    end

    assign bus.x     = x_q;
    assign bus.y     = y_q;
    assign bus.color = color_q;
    assign bus.plot  = plot_q;
    assign bus.busy  = (state_q == DRAW);
    assign bus.done  = (state_q == FIN);

endmodule

// File: tb/tb_vga_rect_plotter.sv
// tb_vga_rect_plotter
//   Directed testbench for vga_rect_plotter: fill, outline, clipping, zero
//   size, start-while-busy, reset mid-draw and a width-1 outline.
module tb_vga_rect_plotter;

    logic clk = 1'b0;
    logic rst;
    int   vectors     = 0;
    int   miscompares = 0;

    vga_rect_plotter_if #(.X_W(8), .Y_W(7), .COLOR_W(3)) bus ();

    vga_rect_plotter #(
        .X_W(8), .Y_W(7), .COLOR_W(3), .SCREEN_W(160), .SCREEN_H(120)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // 100 MHz clock.
    always #5 clk = ~clk;

    // Advance to just after the next rising edge, so that outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one command onto the bus.
    task automatic applyStimulus(input int x0v, input int y0v, input int wv, input int hv,
                                 input int colv, input bit outl, input bit st);
        bus.x0       = 8'(x0v);
        bus.y0       = 7'(y0v);
        bus.w        = 8'(wv);
        bus.h        = 7'(hv);
        bus.color_in = 3'(colv);
        bus.outline  = outl;
        bus.start    = st;
    endtask

    // Issue a command, then check every pixel cycle and the done cycle.
    // When restartAt is nonzero, a conflicting start is raised during cycle
    // N+restartAt.
    task automatic drawAndCheck(input int x0v, input int y0v, input int wv, input int hv,
                                input int colv, input bit outl, input int expPlots,
                                input int restartAt);
        int  obsPlots = 0;
        int  c, r;
        bit  expPlot;
        applyStimulus(x0v, y0v, wv, hv, colv, outl, 1'b1);
        tick();
        bus.start = 1'b0;
        for (int k = 1; k <= wv * hv; k++) begin
            c = (k - 1) % wv;
            r = (k - 1) / wv;
            expPlot = (x0v + c < 160) && (y0v + r < 120) &&
                      (!outl || c == 0 || c == wv - 1 || r == 0 || r == hv - 1);
            checkOutput("plot", 32'(bus.plot), 32'(expPlot));
            checkOutput("busy", 32'(bus.busy), 32'd1);
            checkOutput("done_early", 32'(bus.done), 32'd0);
            if (expPlot) begin
                checkOutput("x", 32'(bus.x), 32'(x0v + c));
                checkOutput("y", 32'(bus.y), 32'(y0v + r));
                checkOutput("color", 32'(bus.color), 32'(colv));
            end
            obsPlots += int'(bus.plot);
            if (restartAt != 0 && k == restartAt) begin
                applyStimulus(50, 60, 2, 2, 5, 1'b0, 1'b1);
            end
            if (restartAt != 0 && k == restartAt + 1) begin
                bus.start = 1'b0;
            end
            tick();
        end
        checkOutput("done", 32'(bus.done), 32'd1);
        checkOutput("busy_at_done", 32'(bus.busy), 32'd0);
        checkOutput("plot_at_done", 32'(bus.plot), 32'd0);
        checkOutput("plot_count", 32'(obsPlots), 32'(expPlots));
        tick();
        checkOutput("done_pulse_end", 32'(bus.done), 32'd0);
        checkOutput("idle_busy", 32'(bus.busy), 32'd0);
    endtask

    // Directed sequence.
    initial begin
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 1'b0, 1'b0);
        tick();
        tick();
        checkOutput("rst_x", 32'(bus.x), 32'd0);
        checkOutput("rst_y", 32'(bus.y), 32'd0);
        checkOutput("rst_color", 32'(bus.color), 32'd0);
        checkOutput("rst_plot", 32'(bus.plot), 32'd0);
        checkOutput("rst_busy", 32'(bus.busy), 32'd0);
        checkOutput("rst_done", 32'(bus.done), 32'd0);
        rst = 1'b0;
        tick();

        $display("[TB] fill 4x3 at (10,20)");
        drawAndCheck(10, 20, 4, 3, 3, 1'b0, 12, 0);

        $display("[TB] outline 4x3 at (10,20)");
        drawAndCheck(10, 20, 4, 3, 3, 1'b1, 10, 0);

        $display("[TB] clipped 4x4 at (158,118)");
        drawAndCheck(158, 118, 4, 4, 6, 1'b0, 4, 0);

        $display("[TB] zero width");
        applyStimulus(5, 5, 0, 5, 2, 1'b0, 1'b1);
        tick();
        bus.start = 1'b0;
        checkOutput("zero_done", 32'(bus.done), 32'd1);
        checkOutput("zero_busy", 32'(bus.busy), 32'd0);
        checkOutput("zero_plot", 32'(bus.plot), 32'd0);
        tick();
        checkOutput("zero_done_end", 32'(bus.done), 32'd0);
        checkOutput("zero_busy_end", 32'(bus.busy), 32'd0);

        $display("[TB] start while busy");
        drawAndCheck(10, 20, 4, 3, 3, 1'b0, 12, 3);
        tick();
        checkOutput("no_queued_busy", 32'(bus.busy), 32'd0);
        checkOutput("no_queued_done", 32'(bus.done), 32'd0);

        $display("[TB] reset mid-draw");
        applyStimulus(10, 20, 4, 3, 3, 1'b0, 1'b1);
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("midrst_plot", 32'(bus.plot), 32'd0);
        checkOutput("midrst_busy", 32'(bus.busy), 32'd0);
        checkOutput("midrst_done", 32'(bus.done), 32'd0);
        tick();
        checkOutput("midrst_no_done", 32'(bus.done), 32'd0);
        drawAndCheck(10, 20, 4, 3, 6, 1'b1, 10, 0);

        $display("[TB] width-1 outline");
        drawAndCheck(30, 40, 1, 3, 2, 1'b1, 3, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
